// File: rtl/shift_reg_pkg.sv
// Shared types for the shift/rotate engine: operation codes and FSM states.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Shift and rotate codes take a step count; everything else finishes on
    // the edge that accepts the command.
    function automatic logic is_step_op(input op_e o);
        return (o == OP_SHL) || (o == OP_SHR) || (o == OP_ROL) ||
               (o == OP_ROR) || (o == OP_ASR);
    endfunction

    // Rotates use the amount as given; shifts saturate at the register width
    // because every bit is already replaced after WIDTH steps.
    function automatic logic is_rotate(input op_e o);
        return (o == OP_ROL) || (o == OP_ROR);
    endfunction

endpackage

// File: rtl/shift_reg_engine_reg_en_n.sv
// WIDTH-bit register with synchronous active-high reset and a load enable.
module reg_en_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over enable; otherwise load d only when enabled.
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/shift_reg_engine.sv
// Multi-mode shift/rotate register with a valid/ready command port.
// One bit-step per enabled cycle; done pulses once the result is on q.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a command; single-step ops complete on accept
//   SHIFT | multi-step op in flight; remaining counts steps still to do
module shift_reg_engine
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    state_e           state, state_next;
    op_e              op_r, op_next;
    op_e              op_in;
    op_e              cur_op;
    logic [AMT_W-1:0] remaining, remaining_next;
    logic [AMT_W-1:0] k;
    logic             sout_next;
    logic             done_next;
    logic             accept;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] step_q;
    logic             step_out;

    assign op_in     = op_e'(op);
    assign cmd_ready = (state == IDLE);
    assign busy      = !cmd_ready;
    assign accept    = cmd_valid & cmd_ready & en;

    // While idle the incoming op steers the step mux; once shifting, the
    // op latched at acceptance does, so op changes mid-flight are ignored.
    assign cur_op = (state == IDLE) ? op_in : op_r;

    // Effective step count for the incoming command.
    always_comb begin
        k = amt;
        if (!is_rotate(op_in) && (amt > WIDTH_AMT))
            k = WIDTH_AMT;
    end

    // Single bit-step of the current operation.
    always_comb begin
        step_q   = q;
        step_out = sout;
        unique case (cur_op)
            OP_SHL: begin
                step_q   = {q[WIDTH-2:0], sin};
                step_out = q[WIDTH-1];
            end
            OP_SHR: begin
                step_q   = {sin, q[WIDTH-1:1]};
                step_out = q[0];
            end
            OP_ASR: begin
                step_q   = {q[WIDTH-1], q[WIDTH-1:1]};
                step_out = q[0];
            end
            OP_ROL: begin
                step_q   = {q[WIDTH-2:0], q[WIDTH-1]};
                step_out = q[WIDTH-1];
            end
            OP_ROR: begin
                step_q   = {q[0], q[WIDTH-1:1]};
                step_out = q[0];
            end
            default: begin
                step_q   = q;
                step_out = sout;
            end
        endcase
    end

    // Next-state, counter, data and completion logic.
    always_comb begin
        state_next     = state;
        op_next        = op_r;
        remaining_next = remaining;
        q_next         = q;
        sout_next      = sout;
        done_next      = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    done_next = 1'b1;
                    op_next   = op_in;
                    if (op_in == OP_LOAD) begin
                        q_next    = d;
                        sout_next = 1'b0;
                    end else if (op_in == OP_CLR) begin
                        q_next    = '0;
                        sout_next = 1'b0;
                    end else if (is_step_op(op_in) && (k != '0)) begin
                        q_next    = step_q;
                        sout_next = step_out;
                        if (k > AMT_W'(1)) begin
                            state_next     = SHIFT;
                            remaining_next = k - AMT_W'(1);
                            done_next      = 1'b0;
                        end
                    end
                end
            end
            SHIFT: begin
                q_next         = step_q;
                sout_next      = step_out;
                remaining_next = remaining - AMT_W'(1);
                if (remaining == AMT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Control registers; en=0 freezes everything, including a pending done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_r      <= OP_HOLD;
            remaining <= '0;
            sout      <= 1'b0;
            done      <= 1'b0;
        end else if (en) begin
            state     <= state_next;
            op_r      <= op_next;
            remaining <= remaining_next;
            sout      <= sout_next;
            done      <= done_next;
        end
    end

    reg_en_n #(
        .WIDTH (WIDTH)
    ) u_q_reg (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .d   (q_next),
        .q   (q)
    );

endmodule

// File: tb/tb_shift_reg_engine.sv
// Directed bench for shift_reg_engine at WIDTH=8.
module tb_shift_reg_engine;

    localparam int WIDTH = 8;
    localparam int AMT_W = 4;

    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROL = 3'd4, ROR = 3'd5, ASR = 3'd6, CLR = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    shift_reg_engine #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .op        (op),
        .amt       (amt),
        .d         (d),
        .sin       (sin),
        .q         (q),
        .sout      (sout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for exactly one edge.
    task automatic issue(input logic [2:0] o, input logic [AMT_W-1:0] a,
                         input logic [WIDTH-1:0] dv);
        op        = o;
        amt       = a;
        d         = dv;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Tick until done, returning edges since acceptance (acceptance = 1).
    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; op = HOLD; amt = '0; d = '0; sin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total++; if (q !== 8'h00)     begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
        total++; if (sout !== 1'b0)   begin bad++; $display("FAIL reset_sout got=%b exp=0", sout); end
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            begin bad++; $display("FAIL reset_ready got=%b/%b exp=1/0", cmd_ready, busy); end
    endtask

    task automatic test_load();
        issue(LOAD, '0, 8'hA5);
        total++; if (q !== 8'hA5)   begin bad++; $display("FAIL load_q got=%h exp=a5", q); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL load_done got=%b exp=1", done); end
        total++; if (sout !== 1'b0) begin bad++; $display("FAIL load_sout got=%b exp=0", sout); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL load_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_shl();
        logic [WIDTH-1:0] exp_q [3] = '{8'h4B, 8'h97, 8'h2F};
        logic             exp_b [3] = '{1'b1, 1'b1, 1'b0};
        logic             exp_dn[3] = '{1'b0, 1'b0, 1'b1};
        int               done_cnt = 0;
        sin = 1'b1;
        issue(SHL, 4'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            if (done) done_cnt++;
            total++; if (q !== exp_q[i] || busy !== exp_b[i] || done !== exp_dn[i])
                begin bad++; $display("FAIL shl_step%0d got q=%h busy=%b done=%b exp q=%h busy=%b done=%b",
                                      i, q, busy, done, exp_q[i], exp_b[i], exp_dn[i]); end
        end
        total++; if (sout !== 1'b1) begin bad++; $display("FAIL shl_sout got=%b exp=1", sout); end
        tick();
        if (done) done_cnt++;
        total++; if (done_cnt != 1) begin bad++; $display("FAIL shl_done_count got=%0d exp=1", done_cnt); end
        sin = 1'b0;
    endtask

    task automatic test_asr_clamp();
        int n;
        issue(LOAD, '0, 8'h80);
        issue(ASR, 4'd10, 8'h00);
        wait_done(n);
        total++; if (n != 8)        begin bad++; $display("FAIL asr_edges got=%0d exp=8", n); end
        total++; if (q !== 8'hFF)   begin bad++; $display("FAIL asr_q got=%h exp=ff", q); end
        total++; if (sout !== 1'b1) begin bad++; $display("FAIL asr_sout got=%b exp=1", sout); end
    endtask

    task automatic test_ror_wrap();
        int n;
        issue(LOAD, '0, 8'h01);
        issue(ROR, 4'd9, 8'h00);
        wait_done(n);
        total++; if (n != 9)        begin bad++; $display("FAIL ror_edges got=%0d exp=9", n); end
        total++; if (q !== 8'h80)   begin bad++; $display("FAIL ror_q got=%h exp=80", q); end
        total++; if (sout !== 1'b1) begin bad++; $display("FAIL ror_sout got=%b exp=1", sout); end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        issue(LOAD, '0, 8'hFF);
        sin = 1'b0;
        issue(SHR, 4'd6, 8'h00);
        tick(); tick();
        total++; if (q !== 8'h1F || busy !== 1'b1)
            begin bad++; $display("FAIL shr_mid got q=%h busy=%b exp q=1f busy=1", q, busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (q !== 8'h00 || sout !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
            begin bad++; $display("FAIL rst_abort got q=%h sout=%b done=%b ready=%b exp 00/0/0/1",
                                  q, sout, done, cmd_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) seen_done++;
        end
        total++; if (seen_done != 0 || q !== 8'h00)
            begin bad++; $display("FAIL rst_no_done got done_cnt=%0d q=%h exp 0/00", seen_done, q); end
    endtask

    task automatic test_en_stall();
        int n;
        issue(LOAD, '0, 8'h81);
        sin = 1'b0;
        issue(SHL, 4'd4, 8'h00);
        total++; if (q !== 8'h02) begin bad++; $display("FAIL stall_first got=%h exp=02", q); end
        en = 1'b0;
        op = LOAD; d = 8'h00; amt = 4'd0; cmd_valid = 1'b1;
        tick(); tick();
        total++; if (q !== 8'h02 || busy !== 1'b1)
            begin bad++; $display("FAIL stall_frozen got q=%h busy=%b exp q=02 busy=1", q, busy); end
        en = 1'b1;
        n = 3;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        total++; if (n != 6)        begin bad++; $display("FAIL stall_edges got=%0d exp=6", n); end
        total++; if (q !== 8'h10 || sout !== 1'b0)
            begin bad++; $display("FAIL stall_q got q=%h sout=%b exp q=10 sout=0", q, sout); end
        en = 1'b0;
        tick();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_hold got=%b exp=1", done); end
        en = 1'b1;
        tick();
        total++; if (done !== 1'b0 || q !== 8'h10)
            begin bad++; $display("FAIL done_clear got done=%b q=%h exp 0/10", done, q); end
    endtask

    task automatic test_back_to_back();
        issue(LOAD, '0, 8'h3C);
        issue(ROL, 4'd1, 8'h00);
        total++; if (q !== 8'h78 || sout !== 1'b0 || done !== 1'b1)
            begin bad++; $display("FAIL b2b_rol got q=%h sout=%b done=%b exp 78/0/1", q, sout, done); end
        issue(SHL, 4'd0, 8'h00);
        total++; if (q !== 8'h78 || done !== 1'b1)
            begin bad++; $display("FAIL b2b_zero got q=%h done=%b exp 78/1", q, done); end
        issue(ROL, 4'd1, 8'h00);
        issue(HOLD, '0, 8'h55);
        total++; if (q !== 8'hF0 || sout !== 1'b0 || done !== 1'b1)
            begin bad++; $display("FAIL b2b_hold got q=%h sout=%b done=%b exp f0/0/1", q, sout, done); end
        issue(ROL, 4'd1, 8'h00);
        issue(CLR, '0, 8'h55);
        total++; if (q !== 8'h00 || sout !== 1'b0 || done !== 1'b1)
            begin bad++; $display("FAIL b2b_clr got q=%h sout=%b done=%b exp 00/0/1", q, sout, done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_shl();
        test_asr_clamp();
        test_ror_wrap();
        test_reset_mid();
        test_en_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
